uart_cmd_parser: RTL and testbench

//  Sequences the UART receive byte stream into register-write commands for the scope core.

---
 rtl/uart_cmd_parser.sv | 164 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Turns the UART receive byte stream into register-write commands for the
//   scope core. A frame is SYNC, ADDR, DHI, DLO, CHK. A good frame produces one
//   cfg_we strobe and an ACK reply. A frame with a bad checksum or an
//   out-of-range address produces a NAK reply.
//
// Ports
//   clk, rst     single clock domain; rst is synchronous and active-high
//   rx_valid     one-cycle pulse; rx_data holds a received byte
//   tx_busy      the transmitter ignores tx_start while this is high
//   tx_start     one-cycle pulse asking the transmitter to send tx_data
//   tx_data      response byte; stable from when it loads until tx_start
//   cfg_we       one-cycle config write strobe
//   cfg_addr     write address, held between strobes
//   cfg_wdata    write data {DHI,DLO}, held between strobes
//   busy         high whenever the parser is not in IDLE
//   err_count    saturating count of NAKs plus inter-byte timeouts
//
// Handshake: a byte is consumed only in the cycle rx_valid is high; there is
//   no back-pressure toward the receiver. tx_start is raised one cycle after
//   the parser sees tx_busy low while a response is pending.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         NUM_REGS       = 16,
  parameter int         ADDR_W         = 4,
  parameter int         TIMEOUT_CYCLES = 8680,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [15:0]       cfg_wdata,
  output logic              busy,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DHI, S_DLO, S_CHK, S_RESP
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        addr_b_q, addr_b_d;
  logic [7:0]        dhi_q, dhi_d;
  logic [7:0]        dlo_q, dlo_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              cfg_we_q, cfg_we_d;
  logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
  logic [15:0]       cfg_wdata_q, cfg_wdata_d;
  logic [7:0]        err_q, err_d;

  logic in_frame;
  logic timeout;
  logic chk_ok;
  logic err_inc;

  assign in_frame = (state_q == S_ADDR) || (state_q == S_DHI) ||
                    (state_q == S_DLO)  || (state_q == S_CHK);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout  = in_frame && !rx_valid && (timer_q == TIMER_LAST);
  // The range check uses the full address byte, before truncation to ADDR_W.
  assign chk_ok   = (rx_data == (addr_b_q ^ dhi_q ^ dlo_q)) &&
                    ({24'd0, addr_b_q} < NUM_REGS);

  // State register and all other flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      addr_b_q    <= '0;
      dhi_q       <= '0;
      dlo_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      addr_b_q    <= addr_b_d;
      dhi_q       <= dhi_d;
      dlo_q       <= dlo_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      cfg_we_q    <= cfg_we_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      err_q       <= err_d;
    end
  end

  // Next-state, inter-byte timer and frame byte capture.
  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    addr_b_d = addr_b_q;
    dhi_d    = dhi_q;
    dlo_d    = dlo_q;
    if (in_frame && !rx_valid) begin
      timer_d = timer_q + TW'(1);
    end
    if (timeout) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_d = S_ADDR;
        S_ADDR: if (rx_valid) begin addr_b_d = rx_data; state_d = S_DHI; end
        S_DHI:  if (rx_valid) begin dhi_d = rx_data; state_d = S_DLO; end
        S_DLO:  if (rx_valid) begin dlo_d = rx_data; state_d = S_CHK; end
        S_CHK:  if (rx_valid) state_d = S_RESP;
        S_RESP: if (!tx_busy) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Registered outputs: write strobe, response byte, error counter.
  always_comb begin
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    cfg_we_d    = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    err_inc     = timeout;
    if (state_q == S_CHK && rx_valid) begin
      if (chk_ok) begin
        cfg_we_d    = 1'b1;
        cfg_addr_d  = addr_b_q[ADDR_W-1:0];
        cfg_wdata_d = {dhi_q, dlo_q};
        tx_data_d   = ACK_BYTE;
      end else begin
        tx_data_d   = NAK_BYTE;
        err_inc     = 1'b1;
      end
    end
    if (state_q == S_RESP && !tx_busy) begin
      tx_start_d = 1'b1;
    end
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign cfg_we    = cfg_we_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_wdata = cfg_wdata_q;
  assign err_count = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
//   Drives byte streams into uart_cmd_parser. A frame-level reference model
//   predicts config writes, responses, busy and err_count. A monitor compares
//   the DUT against those predictions.
module tb_uart_cmd_parser;
  localparam int TO = 8680;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        busy;
  logic [7:0]  err_count;

  uart_cmd_parser dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy), .err_count(err_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit rand_busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard queues: {addr,wdata} writes and response bytes, with due cycle
  logic [19:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_tx_cyc_q[$];

  // reference model: 0 = hunting for sync, 1 = collecting, 2 = awaiting reply
  int         m_mode = 0;
  logic [7:0] m_frame[$];
  int         m_idle = 0;
  logic [7:0] m_err = 8'd0;
  logic [7:0] m_reply = 8'd0;
  logic [7:0] m_a, m_h, m_l, m_k;
  int         m_c;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always @(posedge clk) begin
    m_c = cyc;
    if (rst) begin
      m_mode = 0;
      m_err  = 8'd0;
      m_frame.delete();
    end else begin
      case (m_mode)
        0: if (rx_valid && rx_data == 8'hA5) begin
             m_mode = 1; m_frame.delete(); m_idle = 0;
           end
        1: if (rx_valid) begin
             m_frame.push_back(rx_data);
             m_idle = 0;
             if (m_frame.size() == 4) begin
               m_a = m_frame[0]; m_h = m_frame[1]; m_l = m_frame[2]; m_k = m_frame[3];
               if (m_k == (m_a ^ m_h ^ m_l) && m_a < 8'd16) begin
                 exp_q.push_back({m_a[3:0], m_h, m_l});
                 exp_cyc_q.push_back(m_c + 1);
                 m_reply = 8'h06;
               end else begin
                 m_reply = 8'h15;
                 m_err = sat_inc(m_err);
               end
               m_mode = 2;
             end
           end else begin
             m_idle++;
             if (m_idle == TO) begin
               m_err = sat_inc(m_err);
               m_mode = 0;
             end
           end
        default: if (!tx_busy) begin
             exp_tx_q.push_back(m_reply);
             exp_tx_cyc_q.push_back(m_c + 1);
             m_mode = 0;
           end
      endcase
    end
    cyc = m_c + 1;
  end

  // monitor
  logic [19:0] got_w;
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("err_count", 32'(err_count), 32'(m_err));
      if (cfg_we) begin
        if (exp_q.size() == 0) begin
          chk("cfg_we_unexpected", 32'(1), 32'(0));
        end else begin
          got_w = {cfg_addr, cfg_wdata};
          chk("cfg_write", 32'(got_w), 32'(exp_q.pop_front()));
          chk("cfg_we_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        end
      end
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        chk("cfg_we_missing", 32'(0), 32'(exp_q.pop_front()));
        void'(exp_cyc_q.pop_front());
      end
      if (tx_start) begin
        if (exp_tx_q.size() == 0) begin
          chk("tx_start_unexpected", 32'(1), 32'(0));
        end else begin
          chk("tx_data", 32'(tx_data), 32'(exp_tx_q.pop_front()));
          chk("tx_start_cycle", 32'(cyc), 32'(exp_tx_cyc_q.pop_front()));
        end
      end
      while (exp_tx_cyc_q.size() > 0 && exp_tx_cyc_q[0] < cyc) begin
        chk("tx_start_missing", 32'(0), 32'(exp_tx_q.pop_front()));
        void'(exp_tx_cyc_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_busy) tx_busy = ($urandom_range(0, 2) == 0);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] k, input int maxgap);
    send_byte(8'hA5); idle($urandom_range(0, maxgap));
    send_byte(a);     idle($urandom_range(0, maxgap));
    send_byte(h);     idle($urandom_range(0, maxgap));
    send_byte(l);     idle($urandom_range(0, maxgap));
    send_byte(k);
  endtask

  logic [7:0] ra, rh, rl, rk;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_cfg_we", 32'(cfg_we), 32'(0));
    chk("rst_cfg_addr", 32'(cfg_addr), 32'(0));
    chk("rst_cfg_wdata", 32'(cfg_wdata), 32'(0));
    chk("rst_err", 32'(err_count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);

    // directed frames: good, bad checksum, address out of range
    send_frame(8'h03, 8'h12, 8'h34, 8'h25, 0); idle(6);
    send_frame(8'h03, 8'h12, 8'h34, 8'h00, 0); idle(6);
    send_frame(8'h20, 8'h00, 8'h01, 8'h21, 0); idle(6);
    chk("err_after_naks", 32'(err_count), 32'(2));

    // timeout, then a byte landing exactly on the expiry cycle
    send_byte(8'hA5); send_byte(8'h03); idle(TO); idle(2);
    chk("timeout_busy", 32'(busy), 32'(0));
    chk("timeout_err", 32'(err_count), 32'(3));
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h12);
    idle(TO - 1);
    send_byte(8'h34); send_byte(8'h25); idle(6);
    chk("expiry_byte_err", 32'(err_count), 32'(3));

    // reply held back by tx_busy; SYNC during reply wait is dropped
    tx_busy = 1'b1;
    send_frame(8'h05, 8'hBE, 8'hEF, 8'h05 ^ 8'hBE ^ 8'hEF, 0);
    idle(100); send_byte(8'hA5); idle(399);
    chk("held_busy", 32'(busy), 32'(1));
    tx_busy = 1'b0;
    idle(3);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h00);
    idle(5);

    // garbage before a frame
    send_byte(8'h00); send_byte(8'hFF);
    send_frame(8'h03, 8'h12, 8'h34, 8'h25, 0); idle(6);

    // reset mid-frame
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h12);
    rst = 1'b1; tick(); rst = 1'b0;
    send_byte(8'h34); send_byte(8'h25); idle(5);
    chk("rst_mid_err", 32'(err_count), 32'(0));

    // randomized frames with random gaps, corruption and tx_busy
    rand_busy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) send_byte(8'($urandom));
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      rh = 8'($urandom); rl = 8'($urandom);
      rk = ra ^ rh ^ rl;
      if ($urandom_range(0, 3) == 0) rk = rk ^ 8'($urandom_range(1, 255));
      send_frame(ra, rh, rl, rk, 3);
      idle($urandom_range(0, 6));
    end
    rand_busy = 0; tx_busy = 1'b0;
    idle(10);

    // saturate the error counter
    for (int i = 0; i < 256; i++) begin
      send_frame(8'h03, 8'h12, 8'h34, 8'h00, 0); idle(3);
    end
    chk("err_saturated", 32'(err_count), 32'(8'hFF));

    idle(5);
    chk("cfg_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("tx_queue_empty", 32'(exp_tx_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
